// File: rtl/ins_queue.sv
// ins_queue: prefetch queue feeding the decoder; the head word is presented as RI, split into opcode and operand fields
module ins_queue #(
    parameter int IW    = 4,
    parameter int OPW   = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [IW-1:0]              dm_i,
    input  logic                       dm_valid_i,
    output logic                       dm_ready_o,
    output logic [IW-1:0]              ri_o,
    output logic [OPW-1:0]             opcode_o,
    output logic [IW-OPW-1:0]          operand_o,
    output logic                       ri_valid_o,
    input  logic                       ri_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       ovf_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    assign full_o     = count_o == CW'(DEPTH);
    assign empty_o    = count_o == '0;
    assign dm_ready_o = !full_o;
    assign ri_valid_o = !empty_o;
    assign push       = dm_valid_i && dm_ready_o;
    assign pop        = ri_valid_o && ri_ready_i;
    assign ri_o       = empty_o ? '0 : mem[rd_ptr];
    assign opcode_o   = ri_o[IW-1 -: OPW];
    assign operand_o  = ri_o[IW-OPW-1:0];

    // DEPTH is a power of two, so the pointers wrap naturally at AW bits
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
            ovf_o   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
            ovf_o   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dm_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (dm_valid_i && full_o) ovf_o <= 1'b1;
            count_o <= count_o + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_ins_queue.sv
// tb_ins_queue: directed vector table, random traffic against a queue model, and async-reset check
module tb_ins_queue;
    logic       clk = 0, run = 0;
    logic       rst_i = 1, flush = 0, dm_valid = 0, ri_ready = 0;
    logic [3:0] dm = 0;
    logic       dm_ready, ri_valid, full, empty, ovf;
    logic [3:0] ri;
    logic [1:0] opcode, operand;
    logic [2:0] count;
    int         errors = 0, checks = 0;
    logic [3:0] mq[$];
    bit         movf = 0;

    typedef struct {
        bit       f, v, r;
        bit [3:0] d;
        int       cnt, ri, ovf;
    } vec_t;

    ins_queue #(.IW(4), .OPW(2), .DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush), .dm_i(dm), .dm_valid_i(dm_valid),
        .dm_ready_o(dm_ready), .ri_o(ri), .opcode_o(opcode), .operand_o(operand),
        .ri_valid_o(ri_valid), .ri_ready_i(ri_ready), .count_o(count), .full_o(full),
        .empty_o(empty), .ovf_o(ovf)
    );

    always #5 if (run) clk = ~clk;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int h;
        h = mq.size() > 0 ? int'(mq[0]) : 0;
        chk("count", int'(count), mq.size());
        chk("ri", int'(ri), h);
        chk("opcode", int'(opcode), h / 4);
        chk("operand", int'(operand), h % 4);
        chk("ri_valid", int'(ri_valid), int'(mq.size() > 0));
        chk("dm_ready", int'(dm_ready), int'(mq.size() < 4));
        chk("full", int'(full), int'(mq.size() == 4));
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("ovf", int'(ovf), int'(movf));
    endtask

    task automatic step(input bit f, input bit v, input bit [3:0] d, input bit r);
        bit ps, pp;
        flush = f; dm_valid = v; dm = d; ri_ready = r;
        @(posedge clk); #1;
        if (f) begin
            mq.delete();
            movf = 0;
        end else begin
            if (v && mq.size() == 4) movf = 1;
            ps = v && mq.size() < 4;
            pp = r && mq.size() > 0;
            if (pp) void'(mq.pop_front());
            if (ps) mq.push_back(d);
        end
        check_model();
    endtask

    vec_t tbl[31];

    initial begin
        tbl = '{
            '{0,1,0,4'hA,1,4'hA,0}, '{0,1,0,4'h3,2,4'hA,0}, '{0,1,0,4'h5,3,4'hA,0}, '{0,1,0,4'hF,4,4'hA,0},
            '{0,0,1,4'h0,3,4'h3,0}, '{0,0,1,4'h0,2,4'h5,0}, '{0,0,1,4'h0,1,4'hF,0}, '{0,0,1,4'h0,0,4'h0,0},
            '{0,1,0,4'h1,1,4'h1,0}, '{0,1,0,4'h2,2,4'h1,0}, '{0,1,1,4'h3,2,4'h2,0}, '{0,1,1,4'h4,2,4'h3,0},
            '{0,1,1,4'h5,2,4'h4,0}, '{0,1,1,4'h6,2,4'h5,0}, '{0,1,1,4'h7,2,4'h6,0}, '{0,1,1,4'h8,2,4'h7,0},
            '{0,0,1,4'h0,1,4'h8,0}, '{0,0,1,4'h0,0,4'h0,0},
            '{0,1,0,4'hC,1,4'hC,0}, '{0,1,0,4'hD,2,4'hC,0}, '{0,1,0,4'hE,3,4'hC,0}, '{0,1,0,4'h1,4,4'hC,0},
            '{0,1,0,4'h7,4,4'hC,1}, '{0,1,0,4'h7,4,4'hC,1}, '{0,1,1,4'h7,3,4'hD,1}, '{1,0,0,4'h0,0,4'h0,0},
            '{0,1,0,4'h2,1,4'h2,0}, '{0,1,0,4'h4,2,4'h2,0}, '{0,1,0,4'h6,3,4'h2,0}, '{1,1,1,4'h9,0,4'h0,0},
            '{0,0,0,4'h0,0,4'h0,0}
        };
        // reset held with no clock edge at all
        #10;
        chk("rst_count", int'(count), 0);
        chk("rst_ri", int'(ri), 0);
        chk("rst_ri_valid", int'(ri_valid), 0);
        chk("rst_dm_ready", int'(dm_ready), 1);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_empty", int'(empty), 1);
        rst_i = 0;
        run = 1;
        foreach (tbl[i]) begin
            step(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d_count", i), int'(count), tbl[i].cnt);
            chk($sformatf("vec%0d_ri", i), int'(ri), tbl[i].ri);
            chk($sformatf("vec%0d_ovf", i), int'(ovf), tbl[i].ovf);
        end
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                 4'($urandom), $urandom_range(0, 2) != 0);
        step(1, 0, 0, 0);
        step(0, 1, 4'hA, 0);
        step(0, 1, 4'hB, 0);
        // async reset asserted mid-cycle must act before the next edge
        @(negedge clk);
        rst_i = 1;
        #1;
        mq.delete();
        movf = 0;
        check_model();
        #1 rst_i = 0;
        step(0, 1, 4'h6, 0);
        chk("post_rst_ri", int'(ri), 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
